conv_sequencer: RTL

//  Hardware sequencer for the 3x3 convolution datapath (Conv + Fsmv + three bram_memory banks).

---
 rtl/conv_pkg.sv | 61 ++++++
 rtl/seq_beat_counter.sv | 26 ++
 rtl/conv_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - state encoding, bank select codes and control bundle for conv_sequencer
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_KLOAD,
    ST_LOAD0,
    ST_LOAD1,
    ST_LOAD2,
    ST_CONV,
    ST_DONE
  } seq_state_e;

  localparam logic [1:0] SEL_CONV = 2'b00;
  localparam logic [1:0] SEL_B0   = 2'b01;
  localparam logic [1:0] SEL_B1   = 2'b10;
  localparam logic [1:0] SEL_B2   = 2'b11;

  localparam int KERNEL_BEATS = 3;
  localparam int RST_CYCLES   = 2;

  typedef struct packed {
    logic       rst_conv;
    logic       rst_fsm;
    logic       k_i;
    logic       sop;
    logic       valid_fsm;
    logic       load;
    logic [1:0] sel;
    logic       kernel_rdy;
    logic       pix_rdy;
    logic       busy;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    rst_conv:   1'b1,
    rst_fsm:    1'b1,
    k_i:        1'b0,
    sop:        1'b0,
    valid_fsm:  1'b0,
    load:       1'b0,
    sel:        SEL_CONV,
    kernel_rdy: 1'b0,
    pix_rdy:    1'b0,
    busy:       1'b0
  };

  function automatic logic [2:0] bank_wen(input seq_state_e s);
    logic [2:0] w;
    w = 3'b000;
    case (s)
      ST_LOAD0: w = 3'b001;
      ST_LOAD1: w = 3'b010;
      ST_LOAD2: w = 3'b100;
      default:  w = 3'b000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/seq_beat_counter.sv
// rtl/seq_beat_counter.sv - clearable up-counter with a terminal-count flag
module seq_beat_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == term);

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - runs reset -> kernel -> bank load -> convolve -> done for the 3x3 conv datapath
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int BIT_LEN    = 8,
  parameter int RAM_WIDTH  = 13,
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10
) (
  input  logic                   i_CLK,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [NB_IMAGE-1:0]    i_img_len,
  input  logic [3*BIT_LEN-1:0]   i_kernel,
  input  logic                   i_kernel_vld,
  output logic                   o_kernel_rdy,
  input  logic [RAM_WIDTH-1:0]   i_pix,
  input  logic                   i_pix_vld,
  output logic                   o_pix_rdy,
  input  logic                   i_eop,
  output logic                   o_rst_conv,
  output logic                   o_k_i,
  output logic                   o_rst_fsm,
  output logic                   o_sop,
  output logic                   o_valid_fsm,
  output logic                   o_load,
  output logic [1:0]             o_sel,
  output logic [BIT_LEN-1:0]     o_kdata0,
  output logic [BIT_LEN-1:0]     o_kdata1,
  output logic [BIT_LEN-1:0]     o_kdata2,
  output logic [RAM_WIDTH-1:0]   o_wdata,
  output logic [NB_ADDRESS-1:0]  o_waddr,
  output logic [2:0]             o_wen,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam logic [31:0] MAX_LEN = 32'd1 << NB_ADDRESS;

  seq_state_e            state;
  ctrl_t                 ctrl;
  logic [NB_ADDRESS-1:0] len_m1;
  logic [NB_ADDRESS-1:0] cnt;
  logic [NB_ADDRESS-1:0] cnt_term;
  logic                  cnt_last;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  beat_kernel;
  logic                  beat_pix;
  logic [31:0]           len_wide;
  logic                  len_ok;

  assign len_wide = 32'(i_img_len);
  assign len_ok   = (len_wide != 32'd0) && (len_wide <= MAX_LEN);

  // Ready is registered and only ever set in the matching state, so it qualifies the beat on its own.
  assign beat_kernel = i_kernel_vld && ctrl.kernel_rdy;
  assign beat_pix    = i_pix_vld && ctrl.pix_rdy;
  assign cnt_en      = (state == ST_RST) || beat_kernel || beat_pix;
  assign cnt_clr     = i_abort || (state == ST_IDLE) || (cnt_en && cnt_last);

  always_comb begin
    cnt_term = len_m1;
    case (state)
      ST_RST:   cnt_term = NB_ADDRESS'(RST_CYCLES - 1);
      ST_KLOAD: cnt_term = NB_ADDRESS'(KERNEL_BEATS - 1);
      default:  cnt_term = len_m1;
    endcase
  end

  seq_beat_counter #(
    .W(NB_ADDRESS)
  ) u_beat_counter (
    .clk  (i_CLK),
    .rst_n(i_reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term),
    .count(cnt),
    .last (cnt_last)
  );

  // Outputs are assigned alongside the next state so each appears one cycle after its cause.
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_IDLE;
      ctrl     <= CTRL_RESET;
      len_m1   <= '0;
      o_kdata0 <= '0;
      o_kdata1 <= '0;
      o_kdata2 <= '0;
      o_wdata  <= '0;
      o_waddr  <= '0;
      o_wen    <= 3'b000;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      ctrl.sop <= 1'b0;
      o_wen    <= 3'b000;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      if (i_abort) begin
        state    <= ST_IDLE;
        ctrl     <= CTRL_RESET;
        o_kdata0 <= '0;
        o_kdata1 <= '0;
        o_kdata2 <= '0;
        o_wdata  <= '0;
        o_waddr  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              if (len_ok) begin
                len_m1    <= NB_ADDRESS'(i_img_len - 1'b1);
                state     <= ST_RST;
                ctrl.busy <= 1'b1;
              end else begin
                o_err <= 1'b1;
              end
            end
          end
          ST_RST: begin
            if (cnt_last) begin
              state           <= ST_KLOAD;
              ctrl.rst_conv   <= 1'b0;
              ctrl.rst_fsm    <= 1'b0;
              ctrl.kernel_rdy <= 1'b1;
            end
          end
          ST_KLOAD: begin
            if (beat_kernel) begin
              o_kdata0 <= i_kernel[BIT_LEN-1:0];
              o_kdata1 <= i_kernel[2*BIT_LEN-1:BIT_LEN];
              o_kdata2 <= i_kernel[3*BIT_LEN-1:2*BIT_LEN];
              if (cnt_last) begin
                state           <= ST_LOAD0;
                ctrl.kernel_rdy <= 1'b0;
                ctrl.pix_rdy    <= 1'b1;
                ctrl.sel        <= SEL_B0;
              end
            end
          end
          ST_LOAD0, ST_LOAD1, ST_LOAD2: begin
            if (beat_pix) begin
              o_wdata <= i_pix;
              o_waddr <= cnt;
              o_wen   <= bank_wen(state);
              if (cnt_last) begin
                if (state == ST_LOAD2) begin
                  state          <= ST_CONV;
                  ctrl.pix_rdy   <= 1'b0;
                  ctrl.sel       <= SEL_CONV;
                  ctrl.k_i       <= 1'b1;
                  ctrl.load      <= 1'b1;
                  ctrl.valid_fsm <= 1'b1;
                  ctrl.sop       <= 1'b1;
                end else begin
                  state    <= (state == ST_LOAD0) ? ST_LOAD1 : ST_LOAD2;
                  ctrl.sel <= (state == ST_LOAD0) ? SEL_B1 : SEL_B2;
                end
              end
            end
          end
          ST_CONV: begin
            if (i_eop) begin
              state          <= ST_DONE;
              ctrl.valid_fsm <= 1'b0;
              ctrl.load      <= 1'b0;
              o_done         <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            ctrl  <= CTRL_RESET;
          end
          default: begin
            state <= ST_IDLE;
            ctrl  <= CTRL_RESET;
          end
        endcase
      end
    end
  end

  assign o_rst_conv   = ctrl.rst_conv;
  assign o_rst_fsm    = ctrl.rst_fsm;
  assign o_k_i        = ctrl.k_i;
  assign o_sop        = ctrl.sop;
  assign o_valid_fsm  = ctrl.valid_fsm;
  assign o_load       = ctrl.load;
  assign o_sel        = ctrl.sel;
  assign o_kernel_rdy = ctrl.kernel_rdy;
  assign o_pix_rdy    = ctrl.pix_rdy;
  assign o_busy       = ctrl.busy;

endmodule
